// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word requests into aligned word
// accesses on a combinational-read, falling-edge-write data memory.
// Sub-word stores are read-modify-write. Byte lanes are big-endian.
module load_store_unit #(
  parameter int MEM_BYTES = 128
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;

  logic        acc_err;
  logic [2:0]  acc_bytes;
  logic [32:0] acc_end;

  // Bit position of the low end of a lane: byte o sits at [31-8o:24-8o],
  // halfword at offset 0 is [31:16] and at offset 2 is [15:0].
  function automatic logic [4:0] byte_base(input logic [1:0] off);
    return {2'd3 - off, 3'b000};
  endfunction

  function automatic logic [4:0] half_base(input logic [1:0] off);
    return off[1] ? 5'd0 : 5'd16;
  endfunction

  // Pull the addressed lane out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[byte_base(off) +: 8];
    h = word[half_base(off) +: 16];
    case (size)
      SZ_BYTE: return {{24{sgn & b[7]}}, b};
      SZ_HALF: return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // Replace the addressed lane of the read word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic [15:0] data);
    logic [31:0] w;
    w = word;
    if (size == SZ_BYTE) w[byte_base(off) +: 8] = data[7:0];
    else                 w[half_base(off) +: 16] = data;
    return w;
  endfunction

  assign req_ready = (state == IDLE);

  // Classify the incoming request: misalignment, illegal size, out of range.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    acc_err   = 1'b0;
    acc_bytes = 3'd1;
    case (req_size)
      SZ_HALF: acc_bytes = 3'd2;
      SZ_WORD: acc_bytes = 3'd4;
      default: acc_bytes = 3'd1;
    endcase
    acc_end = {1'b0, req_addr} + {30'd0, acc_bytes};
    if (req_size == 2'b11)                        acc_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])       acc_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) acc_err = 1'b1;
    if (acc_end > 33'(MEM_BYTES))                 acc_err = 1'b1;
  end

  // Request sequencer with registered memory and response outputs.
  always_ff @(posedge CLK or posedge Reset) begin
    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      state      <= IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_off      <= 2'b00;
      r_wdata    <= 16'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_off    <= req_addr[1:0];
            r_wdata  <= req_wdata[15:0];
            mem_addr <= {req_addr[31:2], 2'b00};
            if (acc_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (!req_we || req_size != SZ_WORD) begin
              state  <= READ;
              mem_rd <= 1'b1;
            end else begin
              state     <= WRITE;
              mem_wr    <= 1'b1;
              mem_wdata <= req_wdata;
            end
          end
        end
        READ: begin
          mem_rd <= 1'b0;
          if (r_we) begin
            state     <= WRITE;
            mem_wr    <= 1'b1;
            mem_wdata <= store_merge(mem_rdata, r_size, r_off, r_wdata);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_extract(mem_rdata, r_size, r_off, r_signed);
          end
        end
        WRITE: begin
          state      <= RESP;
          mem_wr     <= 1'b0;
          mem_wdata  <= 32'd0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 128-byte big-endian memory model.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:127];
  logic [6:0] ma;

  load_store_unit #(.MEM_BYTES(128)) dut (
    .CLK(CLK), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Memory model: combinational big-endian read, write on falling edge.
  assign ma = mem_addr[6:0];
  assign mem_rdata = {mem[ma], mem[ma + 7'd1], mem[ma + 7'd2], mem[ma + 7'd3]};

  always @(negedge CLK) begin
    if (mem_wr) begin
      mem[ma]         = mem_wdata[31:24];
      mem[ma + 7'd1]  = mem_wdata[23:16];
      mem[ma + 7'd2]  = mem_wdata[15:8];
      mem[ma + 7'd3]  = mem_wdata[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request (caller is at a falling edge) and follow it to completion.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                         input int exp_rd, input int exp_wr, input logic [31:0] exp_wdata);
    int lat, nrd, nwr;
    logic [31:0] wd;
    logic bad;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    lat = 1; nrd = 0; nwr = 0; wd = 32'd0; bad = 1'b0;
    while (!resp_valid && lat < 8) begin
      nrd += int'(mem_rd);
      nwr += int'(mem_wr);
      if (mem_wr) wd = mem_wdata;
      if (mem_rd && mem_wr) bad = 1'b1;
      if (!mem_wr && mem_wdata != 32'd0) bad = 1'b1;
      if (resp_err || resp_rdata != 32'd0) bad = 1'b1;
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_nrd"}, 32'(nrd), 32'(exp_rd));
    chk({tag, "_nwr"}, 32'(nwr), 32'(exp_wr));
    chk({tag, "_busybits"}, 32'(bad), 32'd0);
    chk({tag, "_maddr"}, mem_addr, {addr[31:2], 2'b00});
    if (exp_wr > 0) chk({tag, "_wdata"}, wd, exp_wdata);
    @(negedge CLK);
    chk({tag, "_resp_clear"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin : main
    logic [31:0] ba [3];
    logic [1:0]  bs [3];
    logic        bsg [3];
    logic [31:0] bexp [3];
    logic [31:0] got [3];
    int acc [3];
    int idx, nresp, busy;

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;

    // Reset state
    @(negedge CLK);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_memctl", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_mwdata", mem_wdata, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;

    // Word store / word load
    run_req("wst10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 2, 1'b0, 32'd0, 0, 1, 32'h11223344);
    chk("mem10_bytes", {mem[16], mem[17], mem[18], mem[19]}, 32'h11223344);
    run_req("wld10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 2, 1'b0, 32'h11223344, 1, 0, 32'd0);

    // Byte store read-modify-write, then byte loads
    run_req("bst12", 1'b1, 2'b00, 1'b0, 32'h12, 32'h555555AB, 3, 1'b0, 32'd0, 1, 1, 32'h1122AB44);
    run_req("bld12s", 1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 2, 1'b0, 32'hFFFFFFAB, 1, 0, 32'd0);
    run_req("bld12u", 1'b0, 2'b00, 1'b0, 32'h12, 32'd0, 2, 1'b0, 32'h000000AB, 1, 0, 32'd0);
    run_req("bld13u", 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 2, 1'b0, 32'h00000044, 1, 0, 32'd0);

    // Halfword loads
    run_req("wst8001", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8001FFFF, 2, 1'b0, 32'd0, 0, 1, 32'h8001FFFF);
    run_req("hld10s", 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 2, 1'b0, 32'hFFFF8001, 1, 0, 32'd0);
    run_req("hld12u", 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 2, 1'b0, 32'h0000FFFF, 1, 0, 32'd0);
    run_req("hld12s", 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 2, 1'b0, 32'hFFFFFFFF, 1, 0, 32'd0);

    // Halfword store merge
    run_req("hst12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hDEAD1234, 3, 1'b0, 32'd0, 1, 1, 32'h80011234);
    run_req("wld10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 2, 1'b0, 32'h80011234, 1, 0, 32'd0);

    // Error requests
    run_req("e_w11", 1'b0, 2'b10, 1'b0, 32'h11, 32'd0, 1, 1'b1, 32'd0, 0, 0, 32'd0);
    run_req("e_h13", 1'b0, 2'b01, 1'b0, 32'h13, 32'd0, 1, 1'b1, 32'd0, 0, 0, 32'd0);
    run_req("e_sz3", 1'b0, 2'b11, 1'b0, 32'h00, 32'd0, 1, 1'b1, 32'd0, 0, 0, 32'd0);
    run_req("e_w80", 1'b0, 2'b10, 1'b0, 32'h80, 32'd0, 1, 1'b1, 32'd0, 0, 0, 32'd0);
    run_req("e_ws80", 1'b1, 2'b10, 1'b0, 32'h80, 32'hFFFFFFFF, 1, 1'b1, 32'd0, 0, 0, 32'd0);
    run_req("e_b80", 1'b1, 2'b00, 1'b0, 32'h80, 32'h000000FF, 1, 1'b1, 32'd0, 0, 0, 32'd0);

    // Top-of-memory boundary: last byte and last word are legal
    run_req("bst7f", 1'b1, 2'b00, 1'b0, 32'h7F, 32'h0000005A, 3, 1'b0, 32'd0, 1, 1, 32'h0000005A);
    run_req("wld7c", 1'b0, 2'b10, 1'b0, 32'h7C, 32'd0, 2, 1'b0, 32'h0000005A, 1, 0, 32'd0);

    // Reset during the READ of a byte store
    run_req("wst20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 2, 1'b0, 32'd0, 0, 1, 32'hCAFEF00D);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h00000077;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("rmid_rd", 32'(mem_rd), 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("rmid_ready", 32'(req_ready), 32'd1);
    chk("rmid_memctl", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rmid_maddr", mem_addr, 32'd0);
    chk("rmid_mwdata", mem_wdata, 32'd0);
    chk("rmid_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rmid_rdata", resp_rdata, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("rhold_quiet", {30'd0, mem_wr, resp_valid}, 32'd0);
    end
    chk("mem20_bytes", {mem[32], mem[33], mem[34], mem[35]}, 32'hCAFEF00D);
    Reset = 1'b0;
    run_req("wld20", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 2, 1'b0, 32'hCAFEF00D, 1, 0, 32'd0);

    // Three back-to-back loads with req_valid held high
    ba[0] = 32'h10; bs[0] = 2'b10; bsg[0] = 1'b0; bexp[0] = 32'h80011234;
    ba[1] = 32'h10; bs[1] = 2'b00; bsg[1] = 1'b1; bexp[1] = 32'hFFFFFF80;
    ba[2] = 32'h12; bs[2] = 2'b01; bsg[2] = 1'b0; bexp[2] = 32'h00001234;
    for (int i = 0; i < 3; i++) begin acc[i] = 0; got[i] = 32'd0; end
    idx = 0; nresp = 0; busy = 0;
    req_we = 1'b0;
    for (int c = 0; c < 40 && nresp < 3; c++) begin
      if (idx < 3) begin
        req_valid = 1'b1; req_addr = ba[idx]; req_size = bs[idx]; req_signed = bsg[idx];
      end else begin
        req_valid = 1'b0;
      end
      if (req_valid && req_ready) begin
        acc[idx] = c;
        idx++;
      end else if (req_valid && !req_ready) begin
        busy++;
      end
      @(posedge CLK);
      @(negedge CLK);
      if (resp_valid && nresp < 3) begin
        got[nresp] = resp_rdata;
        nresp++;
      end
    end
    req_valid = 1'b0;
    chk("b2b_nresp", 32'(nresp), 32'd3);
    chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'd3);
    chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'd3);
    chk("b2b_busy", 32'(busy), 32'd4);
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_rdata%0d", i), got[i], bexp[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
